prio_encoder_pipe: RTL and testbench
====================================

PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL be the number of request bits; the legal range is 2..64.
REQ-002 Parameter MSB_FIRST, default 0; 0 SHALL give the lowest set index priority, 1 SHALL give the highest set index priority.
REQ-003 Localparam IDX_W SHALL be defined as clog2(WIDTH).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk SHALL be an input, 1 bit wide, and SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-006 rst SHALL be an input, 1 bit wide, and SHALL be the synchronous active-high reset.
REQ-007 in_data SHALL be an input, WIDTH bits wide, carrying the request vector.
REQ-008 in_valid SHALL be an input, 1 bit wide, indicating that in_data is valid.
REQ-009 in_ready SHALL be an output, 1 bit wide, indicating that the block can accept in_data.
REQ-010 out_idx SHALL be an output, IDX_W bits wide, carrying the encoded index of the winning bit.
REQ-011 out_none SHALL be an output, 1 bit wide, set when the accepted vector was all zeros.
REQ-012 out_multi SHALL be an output, 1 bit wide, set when the accepted vector had two or more bits set.
REQ-013 out_valid SHALL be an output, 1 bit wide, indicating that the result register holds a valid result.
REQ-014 out_ready SHALL be an input, 1 bit wide, driven by the consumer to accept the result.

Function
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally; it SHALL be 0 while rst is high.
REQ-016 An input transfer SHALL occur when in_valid && in_ready on a rising clk edge.
REQ-017 On an input transfer, the result SHALL be registered; out_valid=1 with the new out_idx/out_none/out_multi on the following cycle, giving a latency of exactly 1 cycle.
REQ-018 An output transfer SHALL occur when out_valid && out_ready; out_valid SHALL fall after it unless an input transfer occurs on the same edge.
REQ-019 Simultaneous input and output transfers SHALL replace the result register with the new result, keep out_valid=1, and drop no bubble.
REQ-020 While out_valid && !out_ready, out_idx, out_none and out_multi SHALL remain stable and no input SHALL be accepted.
REQ-021 Fixed priority: out_idx SHALL be the lowest set index (MSB_FIRST=0) or the highest set index (MSB_FIRST=1).
REQ-022 An all-zero vector SHALL give out_none=1, out_idx=0, out_multi=0.
REQ-023 A one-hot vector SHALL give out_multi=0 and out_idx equal to the bit position.
REQ-024 in_data SHALL be ignored when no input transfer occurs; its X or unknown bits then SHALL NOT affect outputs.
REQ-025 There SHALL be no internal state beyond the result register, out_valid and the optional rotation pointer (REQ-029).

Reset
REQ-026 Reset SHALL be synchronous: while rst=1 at a clk edge, out_valid=0, out_idx=0, out_none=0, out_multi=0, and the pointer=0.
REQ-027 Reset SHALL take priority over any simultaneous transfer; a result pending mid-operation SHALL be discarded and SHALL NOT be presented after reset.
REQ-028 The first input transfer SHALL be possible on the first edge with rst=0.

Configuration
REQ-029 Macro PRIO_ENCODER_PIPE_ROUND_ROBIN_EN defined: an IDX_W-bit rotating pointer SHALL be compiled in.
- The search SHALL start at the pointer and proceed ascending, wrapping at WIDTH-1 to 0.
- MSB_FIRST SHALL be ignored.
- After an input transfer with a nonzero vector, the pointer SHALL become (winner+1) mod WIDTH; for WIDTH not a power of two, winner WIDTH-1 SHALL give pointer 0.
- After an all-zero transfer, the pointer SHALL be unchanged.
REQ-030 Macro undefined: no pointer register SHALL exist, and behaviour SHALL be pure fixed priority per REQ-021.

Verification
REQ-031 The bench SHALL cover these scenarios with WIDTH=4, MSB_FIRST=0, out_ready=1:
- in_data 0001, 0010, 0100, 1000 -> out_idx 00, 01, 10, 11 one cycle later; out_multi=0 and out_none=0 for each.
- in_data 0110 -> out_idx=01, out_multi=1; with MSB_FIRST=1 -> out_idx=10.
- in_data 0000 -> out_none=1, out_idx=00, out_valid=1.
- Backpressure: accept 0100, then hold out_ready=0 for 3 cycles while in_valid=1 with 0001 -> out_idx stays 10, in_ready=0; release -> next result 00 appears after 1 cycle.
- Reset mid-operation: out_valid=1 pending, assert rst one cycle -> out_valid=0 next edge, stale result never presented.
- With PRIO_ENCODER_PIPE_ROUND_ROBIN_EN defined: 1111 five times -> out_idx 0,1,2,3,0; then 0000 -> pointer unchanged; then 1001 -> out_idx 3 (pointer 1 search: 1,2,3).

Source files
------------

// File: rtl/prio_encoder_pipe.sv
// Registered priority encoder with a valid/ready handshake and a one-entry result register.
// Define PRIO_ENCODER_PIPE_ROUND_ROBIN_EN to compile in a rotating search pointer.
module prio_encoder_pipe #(
    parameter  int WIDTH     = 8,
    parameter  int MSB_FIRST = 0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_none,
    output logic             out_multi,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [IDX_W-1:0] win_idx;
    logic             multi_c;
    logic             accept;

    // The result register may refill on the same edge it drains, so a held
    // result only blocks input while the consumer is stalling.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign multi_c  = |(in_data & (in_data - WIDTH'(1)));

`ifdef PRIO_ENCODER_PIPE_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   ptr;
    logic [2*WIDTH-1:0] rot_wide;
    logic [WIDTH-1:0]   rot;
    int                 pos;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    assign rot_wide = {in_data, in_data} >> ptr;
    assign rot      = rot_wide[WIDTH-1:0];

    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
        win_idx = '0;
        pos     = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = int'(ptr) + i;
                if (pos >= WIDTH) pos = pos - WIDTH;
                win_idx = IDX_W'(pos);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && (|in_data)) begin
            ptr <= (win_idx == IDX_W'(WIDTH - 1)) ? '0 : IDX_W'(win_idx + 1'b1);
        end
    end
`else
    always_comb begin
        win_idx = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_data[i]) win_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_data[i]) win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_none  <= 1'b0;
            out_multi <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= win_idx;
            out_none  <= ~|in_data;
            out_multi <= multi_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Self-checking bench for prio_encoder_pipe (WIDTH=4); a scoreboard queue holds expected results.
module tb_prio_encoder_pipe;

    localparam int W = 4;

    typedef struct {
        logic [1:0] idx_lo;
        logic [1:0] idx_hi;
        logic       none;
        logic       multi;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, in_ready_hi;
    logic [1:0]   out_idx, out_idx_hi;
    logic         out_none, out_none_hi, out_multi, out_multi_hi, out_valid, out_valid_hi;

    exp_t         exp_q[$];
    logic         m_valid = 1'b0;
    logic [1:0]   m_ptr = 2'd0;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    prio_encoder_pipe #(.WIDTH(W), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_idx(out_idx), .out_none(out_none), .out_multi(out_multi),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    prio_encoder_pipe #(.WIDTH(W), .MSB_FIRST(1)) dut_hi (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_hi),
        .out_idx(out_idx_hi), .out_none(out_none_hi), .out_multi(out_multi_hi),
        .out_valid(out_valid_hi), .out_ready(out_ready)
    );

    function automatic exp_t model(input logic [W-1:0] d, input logic [1:0] p);
        exp_t e;
        bit   found;
        e.idx_lo = 2'd0;
        e.idx_hi = 2'd0;
        e.none   = (d == '0);
        e.multi  = ($countones(d) > 1);
`ifdef PRIO_ENCODER_PIPE_ROUND_ROBIN_EN
        found = 1'b0;
        for (int k = 0; k < W; k++) begin
            int j;
            j = (int'(p) + k) % W;
            if (!found && d[j]) begin
                found = 1'b1;
                e.idx_lo = 2'(j);
            end
        end
        e.idx_hi = e.idx_lo;
`else
        found = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (!found && d[k]) begin
                found = 1'b1;
                e.idx_lo = 2'(k);
            end
        end
        found = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if (!found && d[k]) begin
                found = 1'b1;
                e.idx_hi = 2'(k);
            end
        end
        if (p != p) e.none = 1'bx;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: outputs are checked on the falling edge, the model advances on the rising edge.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
        logic exp_rdy, in_x, out_x;
        exp_t e;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        exp_rdy   = !m_valid || ordy;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("in_ready_hi", 32'(in_ready_hi), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_valid_hi", 32'(out_valid_hi), 32'(m_valid));
        if (m_valid && exp_q.size() > 0) begin
            check("out_idx", 32'(out_idx), 32'(exp_q[0].idx_lo));
            check("out_none", 32'(out_none), 32'(exp_q[0].none));
            check("out_multi", 32'(out_multi), 32'(exp_q[0].multi));
            check("out_idx_hi", 32'(out_idx_hi), 32'(exp_q[0].idx_hi));
        end
        @(posedge clk);
        out_x = m_valid && ordy;
        in_x  = iv && exp_rdy;
        if (out_x && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_x) begin
            e = model(d, m_ptr);
            exp_q.push_back(e);
            if (d != '0) m_ptr = e.idx_lo + 2'd1;
        end
        m_valid = in_x || (m_valid && !out_x);
        #1;
    endtask

    // One reset cycle with an input offered; nothing may be accepted and all state clears.
    task automatic reset_cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
        rst       = 1'b1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        m_ptr   = 2'd0;
        exp_q.delete();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_none", 32'(out_none), 32'd0);
        check("rst_out_multi", 32'(out_multi), 32'd0);
    endtask

    initial begin
        reset_cycle(1'b0, 4'b0000, 1'b1);

        // One-hot vectors, back to back
        cycle(1'b1, 4'b0001, 1'b1);
        cycle(1'b1, 4'b0010, 1'b1);
        cycle(1'b1, 4'b0100, 1'b1);
        cycle(1'b1, 4'b1000, 1'b1);
        // Multi-bit and all-zero vectors
        cycle(1'b1, 4'b0110, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);
        cycle(1'b1, 4'b1011, 1'b1);
        // Idle with unknown data must leave outputs unaffected
        cycle(1'b0, 4'bxxxx, 1'b1);
        cycle(1'b0, 4'bxxxx, 1'b1);

        // Backpressure: 0100 held for three stalled cycles, then drained while 0001 enters
        cycle(1'b1, 4'b0100, 1'b1);
        cycle(1'b1, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0001, 1'b1);
        cycle(1'b0, 4'bxxxx, 1'b1);

        // Reset with a result pending: it must never be presented
        cycle(1'b1, 4'b1000, 1'b0);
        reset_cycle(1'b1, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1);
        // First transfer directly after reset
        reset_cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b1, 4'b0010, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);

`ifdef PRIO_ENCODER_PIPE_ROUND_ROBIN_EN
        // Rotation: 1111 five times walks 0,1,2,3,0; 0000 keeps the pointer; 1001 from pointer 1 picks 3
        reset_cycle(1'b0, 4'b0000, 1'b1);
        for (int n = 0; n < 5; n++) cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);
        cycle(1'b1, 4'b1001, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        check("rr_final_ptr", 32'(m_ptr), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
